riscv_fetch_ctrl: RTL and testbench
===================================

Name: riscv_fetch_ctrl

Overview:
Instruction-fetch sequencer that owns the fetch PC and drives the instruction-memory request/response interface.
It supports one outstanding request, sequential PC advance, redirects from execute (taken branch, JAL/JALR), and a one-entry hold buffer with valid/ready backpressure toward decode.
Responses that belong to squashed fetches are discarded.
It replaces direct PC stepping in the multi-cycle/pipelined core variant.

Parameters:
WORD_LENGTH, 32, width of PC, addresses and instruction words.
PC_OFFSET, 4, sequential PC increment.
RESET_PC, 0, fetch address after reset.

Ports:
clk  in  1  clock, rising edge.
x_reset  in  1  asynchronous active-low reset.
redirect_valid  in  1  execute requests a PC change this cycle.
redirect_pc  in  WORD_LENGTH  redirect target; bits [1:0] are forced to 0 internally.
imem_req_valid  out  1  fetch request valid.
imem_req_ready  in  1  imem accepts the request.
imem_req_addr  out  WORD_LENGTH  fetch address.
imem_rsp_valid  in  1  instruction word returned (one per accepted request, latency ≥1 cycle).
imem_rsp_data  in  WORD_LENGTH  instruction word.
if_valid  out  1  fetched instruction available to decode.
if_ready  in  1  decode accepts the instruction.
if_pc  out  WORD_LENGTH  PC of the presented instruction.
if_inst  out  WORD_LENGTH  presented instruction.

Behaviour:
- Registers:
  - fetch_pc: next address to request.
  - inflight_pc: address of the accepted request.
  - hold_pc, hold_inst: the one-entry hold buffer.
  - state: IDLE, REQ, WAIT, DROP or HOLD.
- Reset (async assert, any state):
  - state=IDLE, fetch_pc=RESET_PC, inflight_pc/hold_pc/hold_inst=0.
  - Outputs: imem_req_valid=0, if_valid=0, imem_req_addr=RESET_PC, if_pc=0, if_inst=0.
  - Reset mid-transaction abandons any in-flight request. imem shares x_reset.
- Output decode (combinational from state/regs):
  - imem_req_valid = (state==REQ).
  - imem_req_addr = fetch_pc.
  - if_valid = (state==HOLD) && !redirect_valid.
  - if_pc = hold_pc, if_inst = hold_inst.
- Redirect has priority over every other event in the same cycle. Every redirect sets fetch_pc<=redirect_pc&~3.
- IDLE: go to REQ unconditionally. The first request is visible 1 cycle after reset deassertion.
- REQ:
  - Handshake (valid&ready): inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+PC_OFFSET.
    - No redirect: go to WAIT.
    - Redirect: fetch_pc<=redirect target, go to DROP. The accepted request is stale.
  - No handshake, redirect: update fetch_pc, stay in REQ. imem_req_addr may change while valid is held; imem samples the address only on the handshake cycle.
  - Otherwise hold.
- WAIT:
  - rsp_valid, no redirect: hold_pc<=inflight_pc, hold_inst<=rsp_data, go to HOLD.
  - rsp_valid and redirect: discard the response, go to REQ.
  - Redirect only: go to DROP.
- DROP:
  - rsp_valid: discard, go to REQ.
  - Redirect in DROP only updates fetch_pc.
- HOLD:
  - if_ready with no redirect (transfer): go to REQ.
  - Redirect: squash the held instruction (if_valid already masked), go to REQ.
  - Otherwise hold; hold_pc/hold_inst stay stable.
- imem_rsp_valid in IDLE, REQ or HOLD is a protocol error; it is ignored with no state change. The bench flags it.
- PC arithmetic is unsigned, modulo 2^WORD_LENGTH. 0xFFFFFFFC+4 wraps to 0x00000000.
- Best-case throughput: one instruction per 3 cycles (REQ→WAIT→HOLD) with 1-cycle imem latency. No request pipelining in this version.

Decomposition:
- Add typedef enum FETCH_STATE {FS_IDLE, FS_REQ, FS_WAIT, FS_DROP, FS_HOLD} to riscv_constants.sv, next to PC_SEL.
- PC_OFFSET default comes from the same package constant.
- No sub-module; the block is a single FSM plus registers. The hold buffer is too small to justify splitting out.

Test Plan:
1. Reset release, imem ready=1, 1-cycle latency, if_ready=1 → requests at 0x0, 0x4, 0x8; if_pc/if_inst pairs match memory; one instruction every 3 cycles.
2. if_ready=0 for 5 cycles in HOLD at pc 0x8 → if_valid stays 1, if_pc=0x8, inst stable, no new imem request; if_ready=1 → next request addr 0xC.
3. Redirect to 0x100 in the WAIT cycle while the response for 0x4 is pending (latency 3) → the 0x4 word is never presented; next request addr 0x100.
4. Redirect to 0x203 in the same cycle as an imem handshake for 0x10 → 0x10 response dropped; next request addr 0x200.
5. Redirect to 0x40 while HOLD presents 0x8 with if_ready=1 → if_valid=0 that cycle, no transfer; next request addr 0x40.
6. x_reset asserted mid-WAIT → outputs reset immediately (no clock edge needed); after release, first request addr RESET_PC. Also cover fetch_pc=0xFFFFFFFC, where the next request addr wraps to 0x0.

Source files
------------

// File: rtl/riscv_fetch_ctrl_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
// Contents: default word/offset widths and the fetch FSM state encoding.
package riscv_fetch_ctrl_pkg;

    localparam int unsigned WORD_LENGTH_DEF = 32;
    localparam int unsigned PC_OFFSET_DEF   = 4;

    // Fetch sequencer states
    typedef enum logic [2:0] {
        FS_IDLE = 3'd0,
        FS_REQ  = 3'd1,
        FS_WAIT = 3'd2,
        FS_DROP = 3'd3,
        FS_HOLD = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/riscv_fetch_ctrl_if.sv
// Bundle of the fetch sequencer's handshake buses: execute redirect,
// instruction-memory request/response, and the decode-side valid/ready.
// Modports:
//   master - the fetch sequencer (drives imem request and decode outputs)
//   slave  - the surrounding core/imem/decode (drives redirect, ready, response)
interface riscv_fetch_ctrl_if
    import riscv_fetch_ctrl_pkg::*;
#(
    parameter int unsigned WORD_LENGTH = WORD_LENGTH_DEF
) ();

    logic                   redirect_valid;
    logic [WORD_LENGTH-1:0] redirect_pc;

    logic                   imem_req_valid;
    logic                   imem_req_ready;
    logic [WORD_LENGTH-1:0] imem_req_addr;
    logic                   imem_rsp_valid;
    logic [WORD_LENGTH-1:0] imem_rsp_data;

    logic                   if_valid;
    logic                   if_ready;
    logic [WORD_LENGTH-1:0] if_pc;
    logic [WORD_LENGTH-1:0] if_inst;

    modport master (
        input  redirect_valid, redirect_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  if_ready,
        output imem_req_valid, imem_req_addr,
        output if_valid, if_pc, if_inst
    );

    modport slave (
        output redirect_valid, redirect_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output if_ready,
        input  imem_req_valid, imem_req_addr,
        input  if_valid, if_pc, if_inst
    );

endinterface

// File: rtl/riscv_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues one outstanding
// imem request at a time, squashes fetches overtaken by an execute redirect,
// and presents each fetched word to decode from a one-entry hold buffer.
// Ports:
//   clk      - rising-edge clock
//   x_reset  - asynchronous active-low reset
//   bus      - riscv_fetch_ctrl_if.master (redirect, imem req/rsp, decode valid/ready)
module riscv_fetch_ctrl
    import riscv_fetch_ctrl_pkg::*;
#(
    parameter int unsigned            WORD_LENGTH = WORD_LENGTH_DEF,
    parameter int unsigned            PC_OFFSET   = PC_OFFSET_DEF,
    parameter logic [WORD_LENGTH-1:0] RESET_PC    = '0
) (
    input  logic               clk,
    input  logic               x_reset,
    riscv_fetch_ctrl_if.master bus
);

    localparam logic [WORD_LENGTH-1:0] PC_STEP = WORD_LENGTH'(PC_OFFSET);

    fetch_state_e           state_q,       state_d;
    logic [WORD_LENGTH-1:0] fetch_pc_q,    fetch_pc_d;
    logic [WORD_LENGTH-1:0] inflight_pc_q, inflight_pc_d;
    logic [WORD_LENGTH-1:0] hold_pc_q,     hold_pc_d;
    logic [WORD_LENGTH-1:0] hold_inst_q,   hold_inst_d;
    logic                   req_valid_q;

    logic                   req_fire;
    logic [WORD_LENGTH-1:0] redirect_target;

    assign req_fire        = req_valid_q & bus.imem_req_ready;
    // Instruction fetch is word aligned; low address bits of the target are dropped
    assign redirect_target = {bus.redirect_pc[WORD_LENGTH-1:2], 2'b00};

    // Next-state and register update decode
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        hold_pc_d     = hold_pc_q;
        hold_inst_d   = hold_inst_q;

        case (state_q)
            FS_IDLE: state_d = FS_REQ;

            FS_REQ: begin
                if (req_fire) begin
                    inflight_pc_d = fetch_pc_q;
                    fetch_pc_d    = fetch_pc_q + PC_STEP;
                    // A request accepted alongside a redirect is already stale
                    state_d       = bus.redirect_valid ? FS_DROP : FS_WAIT;
                end
            end

            FS_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    if (bus.redirect_valid) begin
                        state_d = FS_REQ;
                    end else begin
                        hold_pc_d   = inflight_pc_q;
                        hold_inst_d = bus.imem_rsp_data;
                        state_d     = FS_HOLD;
                    end
                end else if (bus.redirect_valid) begin
                    state_d = FS_DROP;
                end
            end

            // Swallow the response of a squashed fetch before issuing again
            FS_DROP: begin
                if (bus.imem_rsp_valid) begin
                    state_d = FS_REQ;
                end
            end

            FS_HOLD: begin
                if (bus.redirect_valid || bus.if_ready) begin
                    state_d = FS_REQ;
                end
            end

            default: state_d = FS_IDLE;
        endcase

        // Redirect overrides any sequential advance computed above
        if (bus.redirect_valid) begin
            fetch_pc_d = redirect_target;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge x_reset) begin
        if (!x_reset) begin
            state_q       <= FS_IDLE;
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
            hold_pc_q     <= '0;
            hold_inst_q   <= '0;
            req_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            hold_pc_q     <= hold_pc_d;
            hold_inst_q   <= hold_inst_d;
            req_valid_q   <= (state_d == FS_REQ);
        end
    end

    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_req_addr  = fetch_pc_q;
    // A same-cycle redirect squashes the held word before decode can take it
    assign bus.if_valid       = (state_q == FS_HOLD) && !bus.redirect_valid;
    assign bus.if_pc          = hold_pc_q;
    assign bus.if_inst        = hold_inst_q;

endmodule

// File: tb/tb_riscv_fetch_ctrl.sv
// Self-checking bench for riscv_fetch_ctrl: directed scenarios followed by a
// randomized phase, all checked against a transaction-level fetch model.
module tb_riscv_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic x_reset;

    always #5 clk = ~clk;

    riscv_fetch_ctrl_if #(.WORD_LENGTH(32)) bus ();

    riscv_fetch_ctrl #(
        .WORD_LENGTH (32),
        .PC_OFFSET   (4),
        .RESET_PC    (RST_PC)
    ) dut (
        .clk     (clk),
        .x_reset (x_reset),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: what the fetcher owes decode, in transaction terms
    logic        m_first;      // first cycle after reset release
    logic        m_out;        // an accepted request has no response yet
    logic        m_live;       // that outstanding request is still wanted
    logic        m_hold;       // a fetched word is owed to decode
    logic [31:0] m_pend_pc;
    logic [31:0] m_hold_pc;
    logic [31:0] m_exp_addr;   // next address the fetcher should request

    logic [31:0] pres_q[$];    // PCs transferred to decode
    logic [31:0] req_q[$];     // addresses accepted by imem
    int          xfer_cyc[$];

    // Instruction memory model
    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          lat;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_found(input string tag, input logic found);
        checks++;
        assert (found === 1'b1)
        else begin
            failures++;
            $error("FAIL %s observed=timeout expected=event", tag);
        end
    endtask

    task automatic model_reset();
        m_first    = 1'b1;
        m_out      = 1'b0;
        m_live     = 1'b0;
        m_hold     = 1'b0;
        m_pend_pc  = '0;
        m_hold_pc  = '0;
        m_exp_addr = RST_PC;
        mem_busy   = 1'b0;
        mem_cnt    = 0;
        mem_addr   = '0;
        bus.imem_rsp_valid = 1'b0;
    endtask

    task automatic model_check();
        chk("req_valid", 32'(bus.imem_req_valid), 32'(!m_first && !m_out && !m_hold));
        chk("req_addr", bus.imem_req_addr, m_exp_addr);
        chk("if_valid", 32'(bus.if_valid), 32'(m_hold && !bus.redirect_valid));
        if (m_hold) begin
            chk("if_pc", bus.if_pc, m_hold_pc);
            chk("if_inst", bus.if_inst, mem_word(m_hold_pc));
        end
        if (bus.imem_rsp_valid) begin
            chk("rsp_while_requesting", 32'(bus.imem_req_valid), 32'd0);
        end
    endtask

    task automatic model_update(input logic hs, input logic xf, input logic rd,
                                input logic rs, input logic [31:0] ad, input logic [31:0] tg);
        m_first = 1'b0;
        if (hs) begin
            m_out      = 1'b1;
            m_live     = 1'b1;
            m_pend_pc  = ad;
            m_exp_addr = ad + 32'd4;
        end
        if (rs && m_out) begin
            m_out = 1'b0;
            if (m_live && !rd) begin
                m_hold    = 1'b1;
                m_hold_pc = m_pend_pc;
            end
        end
        if (xf) begin
            m_hold = 1'b0;
            pres_q.push_back(m_hold_pc);
            xfer_cyc.push_back(cyc);
        end
        if (rd) begin
            m_exp_addr = {tg[31:2], 2'b00};
            m_live     = 1'b0;
            m_hold     = 1'b0;
        end
    endtask

    // One clock cycle: starts and ends just after a falling edge
    task automatic step();
        logic        hs, xf, rd, rs;
        logic [31:0] ad, tg;
        if (x_reset && mem_busy && mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = mem_word(mem_addr);
            end
        end
        #1;
        if (x_reset) model_check();
        hs = bus.imem_req_valid & bus.imem_req_ready;
        xf = bus.if_valid & bus.if_ready;
        rd = bus.redirect_valid;
        rs = bus.imem_rsp_valid;
        ad = bus.imem_req_addr;
        tg = bus.redirect_pc;
        @(posedge clk);
        if (x_reset) begin
            model_update(hs, xf, rd, rs, ad, tg);
            if (hs) begin
                mem_busy = 1'b1;
                mem_cnt  = lat;
                mem_addr = ad;
                req_q.push_back(ad);
            end
            if (rs) mem_busy = 1'b0;
        end
        cyc++;
        @(negedge clk);
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
    endtask

    // Asynchronous reset with immediate output checks, then release
    task automatic do_reset();
        x_reset = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        #1;
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_req_addr", bus.imem_req_addr, RST_PC);
        chk("rst_if_pc", bus.if_pc, 32'd0);
        chk("rst_if_inst", bus.if_inst, 32'd0);
        model_reset();
        pres_q.delete();
        req_q.delete();
        xfer_cyc.delete();
        @(negedge clk);
        @(negedge clk);
        x_reset = 1'b1;
        cyc = 0;
    endtask

    task automatic step_until_hs(input logic [31:0] a, input int budget, input string tag);
        logic found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            found = bus.imem_req_valid && bus.imem_req_ready && (bus.imem_req_addr == a);
            step();
        end
        chk_found(tag, found);
    endtask

    task automatic step_until_xfer(input int budget, input string tag);
        logic found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            found = bus.if_valid && bus.if_ready;
            step();
        end
        chk_found(tag, found);
    endtask

    task automatic step_until_req(input int budget, input string tag);
        logic found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.imem_req_valid) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk_found(tag, found);
    endtask

    initial begin
        int n;
        logic found;
        x_reset            = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.if_ready       = 1'b1;
        lat                = 1;
        model_reset();
        @(negedge clk);
        do_reset();

        // Sequential fetch, one instruction every three cycles
        for (int i = 0; i < 9; i++) step();
        chk("t1_nreq", 32'(req_q.size()), 32'd3);
        if (req_q.size() == 3) begin
            for (int i = 0; i < 3; i++) chk("t1_req_addr", req_q[i], 32'(4 * i));
        end
        chk("t1_npres", 32'(pres_q.size()), 32'd2);
        if (pres_q.size() == 2) begin
            chk("t1_pres0", pres_q[0], 32'h0);
            chk("t1_pres1", pres_q[1], 32'h4);
            chk("t1_spacing", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd3);
        end

        // Decode stalls while 0x8 is held
        bus.if_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_if_valid", 32'(bus.if_valid), 32'd1);
            chk("t2_if_pc", bus.if_pc, 32'h8);
            chk("t2_if_inst", bus.if_inst, mem_word(32'h8));
            chk("t2_no_req", 32'(bus.imem_req_valid), 32'd0);
            step();
        end
        bus.if_ready = 1'b1;
        step();
        chk("t2_next_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("t2_next_addr", bus.imem_req_addr, 32'hC);

        // Redirect while the 0x4 response is still in flight
        do_reset();
        lat = 3;
        step_until_hs(32'h4, 40, "t3_hs4");
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        step();
        bus.redirect_valid = 1'b0;
        step_until_req(10, "t3_req");
        chk("t3_addr", bus.imem_req_addr, 32'h100);
        step_until_xfer(20, "t3_xfer");
        chk("t3_npres", 32'(pres_q.size()), 32'd2);
        if (pres_q.size() == 2) chk("t3_pres", pres_q[1], 32'h100);

        // Redirect in the same cycle as the 0x10 handshake
        lat = 1;
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h10;
        step();
        bus.redirect_valid = 1'b0;
        bus.imem_req_ready = 1'b1;
        chk("t4_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("t4_req_addr", bus.imem_req_addr, 32'h10);
        n = pres_q.size();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h203;
        step();
        bus.redirect_valid = 1'b0;
        chk("t4_drop_noreq", 32'(bus.imem_req_valid), 32'd0);
        step_until_req(10, "t4_req");
        chk("t4_addr", bus.imem_req_addr, 32'h200);
        step_until_xfer(20, "t4_xfer");
        chk("t4_npres", 32'(pres_q.size()), 32'(n + 1));
        if (pres_q.size() > 0) chk("t4_pres", pres_q[$], 32'h200);

        // Redirect squashes the held 0x8 even with decode ready
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8;
        step();
        bus.redirect_valid = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.if_ready       = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.if_valid && bus.if_pc == 32'h8) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk_found("t5_hold8", found);
        bus.if_ready       = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        #1;
        chk("t5_if_valid_masked", 32'(bus.if_valid), 32'd0);
        n = pres_q.size();
        step();
        bus.redirect_valid = 1'b0;
        chk("t5_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("t5_req_addr", bus.imem_req_addr, 32'h40);
        chk("t5_no_xfer", 32'(pres_q.size()), 32'(n));

        // Reset in the middle of a wait, then PC wrap at the top of memory
        lat = 3;
        step_until_hs(32'h40, 5, "t6_hs40");
        do_reset();
        step();
        chk("t6_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("t6_req_addr", bus.imem_req_addr, RST_PC);
        lat = 1;
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFF;
        step();
        bus.redirect_valid = 1'b0;
        bus.imem_req_ready = 1'b1;
        chk("t6_top_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
        step_until_xfer(10, "t6_xfer");
        if (pres_q.size() > 0) chk("t6_top_pres", pres_q[$], 32'hFFFF_FFFC);
        chk("t6_wrap_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("t6_wrap_addr", bus.imem_req_addr, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end
            bus.imem_req_ready = ($urandom_range(0, 3) != 0);
            bus.if_ready       = ($urandom_range(0, 2) != 0);
            bus.redirect_valid = ($urandom_range(0, 9) == 0);
            bus.redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                              : 32'($urandom);
            lat = $urandom_range(1, 3);
            step();
        end
        bus.redirect_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
